// File: rtl/hamming_encode_tx.sv
// Hamming(7,4) encoder with an MSB-first serial transmitter.
// A 4-bit word is accepted over valid/ready, encoded into the standard
// 7-bit layout, held on H, and shifted out on tx, BIT_CYCLES clocks per bit.
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both high. in_ready is high only in IDLE (and never while rst is high);
// the producer may change din/in_valid freely while in_ready is low, and
// those changes are ignored until the frame completes.
module hamming_encode_tx #(
  parameter int BIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] din,
  output logic [6:0] H,
  output logic       tx,
  output logic       tx_en,
  output logic       done,
  output logic       fsm_state
);

  // Hold counter is at least one bit wide so BIT_CYCLES = 1 stays legal.
  localparam int HOLD_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BIT_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        idx;
  logic [2:0]        idx_nxt;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_nxt;
  logic [6:0]        h_nxt;
  logic              accept;
  logic              last_hold;

  // Standard layout: data in H6,H5,H4,H2; parity in H3,H1,H0 so that the
  // receiver syndromes {H6^H5^H4^H3, H6^H5^H2^H1, H6^H4^H2^H0} are zero.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    c[6] = d[3];
    c[5] = d[2];
    c[4] = d[1];
    c[3] = d[3] ^ d[2] ^ d[1];
    c[2] = d[0];
    c[1] = d[3] ^ d[2] ^ d[0];
    c[0] = d[3] ^ d[1] ^ d[0];
    return c;
  endfunction

  // Debug view of the FSM: 1 while a frame is being transmitted.
  assign fsm_state = (state == SEND);

  // Next-state and output decode; tx/tx_en/done depend only on registers.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    hold_nxt  = hold;
    h_nxt     = H;
    in_ready  = (state == IDLE) && !rst;
    accept    = in_valid && in_ready;
    last_hold = (hold == HOLD_LAST);
    tx        = 1'b0;
    tx_en     = 1'b0;
    done      = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          h_nxt     = encode(din);
          idx_nxt   = 3'd6;
          hold_nxt  = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        tx    = H[idx];
        tx_en = 1'b1;
        if (last_hold) begin
          hold_nxt = '0;
          if (idx == 3'd0) begin
            // Final hold cycle of the last bit closes the frame.
            done      = 1'b1;
            idx_nxt   = 3'd6;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx - 3'd1;
          end
        end else begin
          hold_nxt = hold + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, bit index, hold counter and codeword registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 3'd6;
      hold  <= '0;
      H     <= 7'h00;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      hold  <= hold_nxt;
      H     <= h_nxt;
    end
  end

endmodule

// File: tb/tb_hamming_encode_tx.sv
// Bench for hamming_encode_tx: one instance with BIT_CYCLES = 1 and one with
// BIT_CYCLES = 3. Drivers push hand-computed codewords into expected queues;
// monitors capture the serial frames and compare when done pulses.
module tb_hamming_encode_tx;

  logic       clk;
  logic       rst1, in_valid1, in_ready1, tx1, tx_en1, done1, st1;
  logic [3:0] din1;
  logic [6:0] h1;
  logic       rst3, in_valid3, in_ready3, tx3, tx_en3, done3, st3;
  logic [3:0] din3;
  logic [6:0] h3;

  logic [6:0] exp_q1[$];
  logic [6:0] exp_q3[$];
  logic [6:0] tbl[16];

  int total;
  int bad;

  hamming_encode_tx #(.BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .din(din1), .H(h1), .tx(tx1), .tx_en(tx_en1), .done(done1),
    .fsm_state(st1)
  );

  hamming_encode_tx #(.BIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_ready(in_ready3),
    .din(din3), .H(h3), .tx(tx3), .tx_en(tx_en3), .done(done3),
    .fsm_state(st3)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] expand3(input logic [6:0] w);
    logic [20:0] r;
    r = '0;
    for (int i = 6; i >= 0; i--) r = {r[17:0], {3{w[i]}}};
    return r;
  endfunction

  function automatic logic [2:0] syndrome(input logic [6:0] c);
    return {c[6] ^ c[5] ^ c[4] ^ c[3], c[6] ^ c[5] ^ c[2] ^ c[1], c[6] ^ c[4] ^ c[2] ^ c[0]};
  endfunction

  // Driver for the BIT_CYCLES = 1 instance; called from a negedge.
  task automatic send1(input logic [3:0] d, input logic [6:0] e);
    int n;
    n = 0;
    while (!in_ready1 && n < 200) begin @(negedge clk); n++; end
    if (!in_ready1) check("send1_ready_timeout", 0, 1);
    in_valid1 = 1'b1;
    din1 = d;
    exp_q1.push_back(e);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    din1 = 4'($urandom_range(0, 15));
  endtask

  // Driver for the BIT_CYCLES = 3 instance.
  task automatic send3(input logic [3:0] d, input logic [6:0] e);
    int n;
    n = 0;
    while (!in_ready3 && n < 200) begin @(negedge clk); n++; end
    if (!in_ready3) check("send3_ready_timeout", 0, 1);
    in_valid3 = 1'b1;
    din3 = d;
    exp_q3.push_back(e);
    @(posedge clk);
    #1;
    in_valid3 = 1'b0;
    din3 = 4'($urandom_range(0, 15));
  endtask

  // Monitor for the BIT_CYCLES = 1 instance.
  initial begin
    int cnt;
    logic [6:0] sh;
    logic [6:0] e;
    cnt = 0;
    sh = '0;
    forever begin
      @(negedge clk);
      if (rst1) begin
        cnt = 0;
        sh = '0;
      end else if (tx_en1) begin
        sh = {sh[5:0], tx1};
        cnt++;
        if (done1) begin
          if (exp_q1.size() == 0) begin
            check("frame1_unexpected", 1, 0);
          end else begin
            e = exp_q1.pop_front();
            check("frame1_len", cnt, 7);
            check("frame1_serial", sh, e);
            check("frame1_h", h1, e);
            check("frame1_syndrome", syndrome(h1), 0);
          end
          cnt = 0;
        end
      end else begin
        if (done1) check("done1_outside_frame", done1, 0);
        if (cnt != 0) begin
          check("frame1_no_done", cnt, 0);
          cnt = 0;
        end
      end
    end
  end

  // Monitor for the BIT_CYCLES = 3 instance.
  initial begin
    int cnt;
    logic [20:0] seq;
    logic rdy_seen;
    logic [6:0] e;
    cnt = 0;
    seq = '0;
    rdy_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst3) begin
        cnt = 0;
        seq = '0;
        rdy_seen = 1'b0;
      end else if (tx_en3) begin
        seq = {seq[19:0], tx3};
        cnt++;
        if (in_ready3) rdy_seen = 1'b1;
        if (done3) begin
          if (exp_q3.size() == 0) begin
            check("frame3_unexpected", 1, 0);
          end else begin
            e = exp_q3.pop_front();
            check("frame3_len", cnt, 21);
            check("frame3_serial", seq, expand3(e));
            check("frame3_h", h3, e);
            check("frame3_ready_low", rdy_seen, 0);
          end
          cnt = 0;
          rdy_seen = 1'b0;
        end
      end else begin
        if (done3) check("done3_outside_frame", done3, 0);
        if (cnt != 0) begin
          check("frame3_no_done", cnt, 0);
          cnt = 0;
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [6:0] w;
    total = 0;
    bad = 0;
    tbl = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
            7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};
    rst1 = 1'b1; rst3 = 1'b1;
    in_valid1 = 1'b0; in_valid3 = 1'b0;
    din1 = 4'h0; din3 = 4'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_h", h1, 7'h00);
    check("rst_tx", tx1, 0);
    check("rst_tx_en", tx_en1, 0);
    check("rst_done", done1, 0);
    check("rst_in_ready", in_ready1, 0);
    check("rst_in_ready3", in_ready3, 0);
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready1, 1);
    check("post_rst_in_ready3", in_ready3, 1);

    // Single word 1011, cycle-exact timing
    in_valid1 = 1'b1;
    din1 = 4'b1011;
    exp_q1.push_back(7'h55);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    w = 7'h55;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("single_tx", tx1, w[6-i]);
      check("single_tx_en", tx_en1, 1);
      check("single_done", done1, (i == 6));
      check("single_in_ready", in_ready1, 0);
      check("single_h", h1, 7'h55);
    end
    @(negedge clk);
    check("single_end_tx_en", tx_en1, 0);
    check("single_end_tx", tx1, 0);
    check("single_end_ready", in_ready1, 1);

    // All 16 data words
    for (int d = 0; d < 16; d++) send1(4'(d), tbl[d]);
    @(negedge clk);

    // Back-to-back with in_valid held high: 4'hF then 4'h0
    while (!in_ready1) @(negedge clk);
    in_valid1 = 1'b1;
    din1 = 4'hF;
    exp_q1.push_back(7'h7F);
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check("b2b_busy_ready", in_ready1, 0);
      check("b2b_h_stable", h1, 7'h7F);
      if (c == 7) begin
        din1 = 4'h0;
        exp_q1.push_back(7'h00);
      end else begin
        din1 = 4'($urandom_range(0, 14));
      end
    end
    @(negedge clk);
    check("b2b_gap_ready", in_ready1, 1);
    check("b2b_gap_tx_en", tx_en1, 0);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    check("b2b_second_tx_en", tx_en1, 1);
    check("b2b_second_h", h1, 7'h00);

    // Reset during the bit-3 cycle
    repeat (8) @(negedge clk);
    send1(4'h6, 7'h33);
    repeat (4) @(negedge clk);
    check("abort_pre_tx_en", tx_en1, 1);
    rst1 = 1'b1;
    void'(exp_q1.pop_back());
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("abort_tx", tx1, 0);
      check("abort_tx_en", tx_en1, 0);
      check("abort_done", done1, 0);
      check("abort_ready", in_ready1, 0);
      check("abort_h", h1, 7'h00);
    end
    rst1 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("abort_no_done", done1, 0);
    end
    send1(4'hD, 7'h66);
    send1(4'h2, 7'h19);

    // BIT_CYCLES = 3
    send3(4'h8, 7'h4B);
    send3(4'h5, 7'h2D);

    // Drain
    for (int n = 0; n < 400 && (exp_q1.size() != 0 || exp_q3.size() != 0); n++) @(negedge clk);
    check("queues_drained", exp_q1.size() + exp_q3.size(), 0);
    repeat (3) @(negedge clk);
    check("final_idle_tx_en", tx_en1 | tx_en3, 0);
    check("final_h_kept", h3, 7'h2D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_encode_tx.md
# hamming_encode_tx

Hamming(7,4) encoder with a serial transmitter. It accepts a 4-bit data word over a valid/ready handshake and computes the 7-bit codeword in the team's standard bit layout. It holds the codeword on a parallel output and shifts it out MSB-first on a single serial line. It sits on the transmit side of the Hamming link; the receive side de-serializes the line and decodes/corrects with the matching layout.

## Interface
- BIT_CYCLES, 1: clock cycles each serial bit is held on `tx`; legal range ≥ 1.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  `din` holds a word to encode.
- in_ready  output  1  encoder can accept a word this cycle.
- din  input  4  data word D[3:0].
- H  output  7  last accepted codeword, registered.
- tx  output  1  serial codeword bit; 0 when idle.
- tx_en  output  1  high while `tx` carries a codeword bit.
- done  output  1  one-cycle pulse in the last cycle of a frame.

## Operation
- Codeword layout: H[6]=D3, H[5]=D2, H[4]=D1, H[3]=D3^D2^D1, H[2]=D0, H[1]=D3^D2^D0, H[0]=D3^D1^D0.
- With this layout, the receiver syndromes {H6^H5^H4^H3, H6^H5^H2^H1, H6^H4^H2^H0} are all zero for every encoded word.
- FSM has two states, IDLE and SEND. It has a 3-bit bit index (6 down to 0) and a hold counter of width max(1, clog2(BIT_CYCLES)).
- **IDLE**
  - in_ready = 1 (0 while rst is high); tx = 0; tx_en = 0.
  - When in_valid & in_ready: H ← encode(din), index ← 6, hold counter ← 0, go to SEND.
- **SEND**
  - in_ready = 0; in_valid and din are ignored.
  - tx = H[index]; tx_en = 1.
  - Hold counter increments each cycle. When it reaches BIT_CYCLES-1, it clears and index decrements.
  - In the final hold cycle of index 0: done = 1, and the next state is IDLE.
- H holds its value until the next accepted word; it is not cleared at frame end.
- tx and tx_en are driven from registered state/index/codeword bits. They are glitch-free and combinationally independent of din and in_valid.
- Reset values: state = IDLE, H = 7'h00, tx = 0, tx_en = 0, done = 0, index = 6, hold counter = 0. in_ready reads 0 while rst is asserted.
- Reset mid-frame aborts the frame. From the cycle after rst is sampled high, tx = 0 and tx_en = 0, and no done pulse is produced.

## Timing
- Handshake is sampled at edge k, so word acceptance takes one cycle. In cycle k+1: H is valid, tx_en = 1, tx = H[6].
- H[6-i] is on tx for cycles k+1+i·BIT_CYCLES through k+(i+1)·BIT_CYCLES, for i = 0..6.
- done is high only in cycle k+7·BIT_CYCLES, the last cycle of H[0].
- In cycle k+7·BIT_CYCLES+1: state is IDLE, tx_en = 0, tx = 0, in_ready = 1.
- Back-to-back words leave exactly one idle cycle between frames. Maximum throughput is one word per 7·BIT_CYCLES+1 cycles.
- in_valid held high continuously: a new word is accepted in the first IDLE cycle after each frame.
- in_valid low in IDLE: the block stays idle indefinitely, and H keeps its last value.

## Test plan
- Reset: assert rst for 2 cycles mid-operation, then release. Required: H = 7'h00, tx = tx_en = done = 0, in_ready = 0 while rst is high; in_ready = 1 the cycle after release.
- Single word, BIT_CYCLES = 1: din = 4'b1011 accepted at edge k. Required: H = 7'h55; tx sequence 1,0,1,0,1,0,1 in cycles k+1..k+7; done only in cycle k+7; tx_en low at k+8.
- All 16 din values, BIT_CYCLES = 1. Required:
  - din = 0 → 7'h00; 4'hF → 7'h7F; 4'h1 → 7'h07; 4'h8 → 7'h4B.
  - Every codeword has all three syndromes = 0.
  - The serially captured bits equal H.
- BIT_CYCLES = 3, din = 4'h8. Required: each bit of 1001011 is held exactly 3 cycles; done is in cycle k+21; in_ready is 0 throughout.
- Back-to-back with in_valid stuck high: din = 4'hF, then 4'h0. Required:
  - The second word is accepted exactly at edge k+8.
  - din changes during SEND do not alter tx or H.
  - The second frame is all zeros with tx_en = 1 for 7 cycles.
- Reset mid-frame: assert rst during the bit-3 cycle. Required: tx = tx_en = 0 the next cycle; no done pulse; a new word accepted after release encodes correctly.
